button_core: RTL and testbench

- Memory-mapped input peripheral on the IO interconnect; the read-side counterpart of the LED output core.
- Synchronises and debounces NUM_BUTTONS raw push-button/switch inputs.
- Latches rising edges into sticky pending bits.
- Returns state to the CPU through registered reads with one-cycle latency.

---
 rtl/button_core_pkg.sv | 37 +++
 rtl/button_core_debouncer.sv | 64 ++++++
 rtl/button_core.sv | 140 ++++++++++++++
 tb/tb_button_core.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_core_pkg.sv
// ---------------------------------------------------------------------------
// button_core_pkg
// Shared definitions for the push-button input core: the MMIO register
// offsets decoded from io_bus_s_address[7:0], an enum naming the decoded
// register, and a helper that maps an offset onto that enum.
// ---------------------------------------------------------------------------
package button_core_pkg;

  // Byte offsets of the button core registers within its chip-select window
  localparam logic [7:0] MMIO_BTN_REG_GET_STATE = 8'h00;
  localparam logic [7:0] MMIO_BTN_REG_GET_EDGE  = 8'h04;
  localparam logic [7:0] MMIO_BTN_REG_CLR_EDGE  = 8'h08;
  localparam logic [7:0] MMIO_BTN_REG_IRQ_EN    = 8'h0C;

  // Decoded register selection; BTN_SEL_NONE covers every unmapped offset
  typedef enum logic [2:0] {
    BTN_SEL_NONE,
    BTN_SEL_STATE,
    BTN_SEL_EDGE,
    BTN_SEL_CLR,
    BTN_SEL_IRQ_EN
  } btn_sel_e;

  // Map a byte offset onto the register it selects
  function automatic btn_sel_e btn_decode(input logic [7:0] offset);
    btn_sel_e sel;
    case (offset)
      MMIO_BTN_REG_GET_STATE: sel = BTN_SEL_STATE;
      MMIO_BTN_REG_GET_EDGE:  sel = BTN_SEL_EDGE;
      MMIO_BTN_REG_CLR_EDGE:  sel = BTN_SEL_CLR;
      MMIO_BTN_REG_IRQ_EN:    sel = BTN_SEL_IRQ_EN;
      default:                sel = BTN_SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/button_core_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
// One button input: 2-flop synchroniser followed by a counter-based
// debouncer. The debounced level only changes after the synchronised input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk      system clock
//   rst      synchronous active-high reset
//   i_btn    raw asynchronous button input
//   o_level  debounced level (registered)
//   o_rise   high for the single cycle whose edge takes o_level 0->1
// ---------------------------------------------------------------------------
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  logic w_differ;
  logic w_flip;

  // The counter can never pass CNT_LAST: reaching it while still differing
  // flips the level, which clears the counter on the same edge.
  assign w_differ = (r_sync2 != r_level);
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  // Combinational so the pending bit in the top sets on the same edge as the level
  assign o_rise  = w_flip && r_sync2;

endmodule

// File: rtl/button_core.sv
// ---------------------------------------------------------------------------
// button_core
// Memory-mapped push-button input peripheral. Debounces NUM_BUTTONS raw
// inputs, latches debounced rising edges into sticky pending bits, and
// returns state to the CPU through registered reads (one-cycle latency,
// zero when not selected so the interconnect can OR slaves together).
//
// Optional feature (macro BUTTON_IRQ_EN): adds the irq_en register at 0x0C
// and the registered output irq = |(edge_pending & irq_en).
//
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   io_bus_s_rd_en    read strobe
//   io_bus_s_wr_en    write strobe
//   io_bus_s_cs       chip select for this core
//   io_bus_s_address  byte address, only [7:0] decoded
//   io_bus_s_wr_data  write data
//   io_bus_s_rd_data  registered read data
//   btn               raw asynchronous button inputs
//   irq               interrupt request (BUTTON_IRQ_EN only)
// ---------------------------------------------------------------------------
module button_core
  import button_core_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   io_bus_s_rd_en,
  input  logic                   io_bus_s_wr_en,
  input  logic                   io_bus_s_cs,
  input  logic [31:0]            io_bus_s_address,
  input  logic [31:0]            io_bus_s_wr_data,
  output logic [31:0]            io_bus_s_rd_data,
  input  logic [NUM_BUTTONS-1:0] btn
`ifdef BUTTON_IRQ_EN
  ,
  output logic                   irq
`endif
);

  logic [NUM_BUTTONS-1:0] w_level;
  logic [NUM_BUTTONS-1:0] w_rise;
  logic [NUM_BUTTONS-1:0] w_clr;
  logic [31:0]            w_state_ext;
  logic [31:0]            w_edge_ext;
  logic [31:0]            w_rd_mux;
  btn_sel_e               w_sel;
  logic                   w_rd_act;
  logic                   w_wr_act;
  logic                   w_unused_bits;

  logic [NUM_BUTTONS-1:0] r_edge;
  logic [31:0]            r_rd_data;

  // One synchroniser + debouncer per button
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (btn[i]),
      .o_level(w_level[i]),
      .o_rise (w_rise[i])
    );
  end

  assign w_sel    = btn_decode(io_bus_s_address[7:0]);
  assign w_rd_act = io_bus_s_cs && io_bus_s_rd_en;
  assign w_wr_act = io_bus_s_cs && io_bus_s_wr_en;

  // Only the low byte of the address is decoded
  assign w_unused_bits = &{1'b0, io_bus_s_address[31:8]};

  assign w_clr = (w_wr_act && (w_sel == BTN_SEL_CLR))
                 ? io_bus_s_wr_data[NUM_BUTTONS-1:0] : '0;

`ifdef BUTTON_IRQ_EN
  logic [NUM_BUTTONS-1:0] r_irq_en;
  logic [31:0]            w_irq_en_ext;
  logic                   r_irq;

  // irq_en is plain RW storage; irq follows the pending bits one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_act && (w_sel == BTN_SEL_IRQ_EN)) begin
        r_irq_en <= io_bus_s_wr_data[NUM_BUTTONS-1:0];
      end
      r_irq <= |(r_edge & r_irq_en);
    end
  end

  always_comb begin
    w_irq_en_ext                  = '0;
    w_irq_en_ext[NUM_BUTTONS-1:0] = r_irq_en;
  end

  assign irq = r_irq;
`endif

  // Zero-extension written as a default plus a slice so NUM_BUTTONS=32 works
  always_comb begin
    w_state_ext                  = '0;
    w_state_ext[NUM_BUTTONS-1:0] = w_level;
    w_edge_ext                   = '0;
    w_edge_ext[NUM_BUTTONS-1:0]  = r_edge;
  end

  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      BTN_SEL_STATE:  w_rd_mux = w_state_ext;
      BTN_SEL_EDGE:   w_rd_mux = w_edge_ext;
`ifdef BUTTON_IRQ_EN
      BTN_SEL_IRQ_EN: w_rd_mux = w_irq_en_ext;
`endif
      default:        w_rd_mux = '0;
    endcase
  end

  // A new rising edge wins over a simultaneous W1C so no event is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge    <= '0;
      r_rd_data <= '0;
    end else begin
      r_edge    <= (r_edge & ~w_clr) | w_rise;
      r_rd_data <= w_rd_act ? w_rd_mux : 32'h0;
    end
  end

  assign io_bus_s_rd_data = r_rd_data;

endmodule

// File: tb/tb_button_core.sv
// ---------------------------------------------------------------------------
// tb_button_core
// Self-checking bench for button_core (NUM_BUTTONS=4, DEBOUNCE_CYCLES=4).
// A behavioural model keeps a history of sampled btn values: a debounced bit
// flips when the last DEBOUNCE_CYCLES synchronised samples all disagree with
// it. Register reads, W1C and irq are predicted from that model.
// ---------------------------------------------------------------------------
module tb_button_core;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdEn = 1'b0;
  logic          wrEn = 1'b0;
  logic          cs = 1'b0;
  logic [31:0]   addr = '0;
  logic [31:0]   wrData = '0;
  logic [31:0]   rdData;
  logic [NB-1:0] btn = '0;
`ifdef BUTTON_IRQ_EN
  logic          irq;
`endif

  int errorCount = 0;
  int checkCount = 0;

  // Model state
  logic [NB-1:0] mLevel = '0;
  logic [NB-1:0] mEdge = '0;
  logic [NB-1:0] mIrqEn = '0;
  logic          mIrq = 1'b0;
  logic [31:0]   mRdData = '0;
  logic [NB-1:0] btnHist[$];

  always #5 clk = ~clk;

  button_core #(
    .NUM_BUTTONS    (NB),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .io_bus_s_rd_en  (rdEn),
    .io_bus_s_wr_en  (wrEn),
    .io_bus_s_cs     (cs),
    .io_bus_s_address(addr),
    .io_bus_s_wr_data(wrData),
    .io_bus_s_rd_data(rdData),
    .btn             (btn)
`ifdef BUTTON_IRQ_EN
    ,
    .irq             (irq)
`endif
  );

  // Count a comparison and report it when observed and expected differ
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Register view of the model
  function automatic logic [31:0] modelRegRead(input logic [7:0] offset);
    logic [31:0] value;
    value = '0;
    if (offset == 8'h00) value[NB-1:0] = mLevel;
    if (offset == 8'h04) value[NB-1:0] = mEdge;
`ifdef BUTTON_IRQ_EN
    if (offset == 8'h0C) value[NB-1:0] = mIrqEn;
`endif
    return value;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelEdge();
    logic [31:0]   nextRd;
    logic          nextIrq;
    logic [NB-1:0] nextLevel;
    logic [NB-1:0] rise;
    logic [NB-1:0] clr;
    logic          allDiffer;
    if (rst) begin
      mLevel  = '0;
      mEdge   = '0;
      mIrqEn  = '0;
      mIrq    = 1'b0;
      mRdData = '0;
      btnHist = {};
      for (int k = 0; k < DB + 2; k++) btnHist.push_back('0);
      return;
    end
    nextRd  = (cs && rdEn) ? modelRegRead(addr[7:0]) : 32'h0;
    nextIrq = |(mEdge & mIrqEn);
    // After this, entry DB+1 is this edge's sample and entries 0..DB-1 are
    // the samples the debouncer sees over its last DB evaluations.
    btnHist.push_back(btn);
    void'(btnHist.pop_front());
    nextLevel = mLevel;
    rise      = '0;
    for (int i = 0; i < NB; i++) begin
      allDiffer = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (btnHist[j][i] == mLevel[i]) allDiffer = 1'b0;
      end
      if (allDiffer) begin
        nextLevel[i] = ~mLevel[i];
        rise[i]      = ~mLevel[i];
      end
    end
    clr = (cs && wrEn && addr[7:0] == 8'h08) ? wrData[NB-1:0] : '0;
`ifdef BUTTON_IRQ_EN
    if (cs && wrEn && addr[7:0] == 8'h0C) mIrqEn = wrData[NB-1:0];
`endif
    mEdge   = (mEdge & ~clr) | rise;
    mLevel  = nextLevel;
    mRdData = nextRd;
    mIrq    = nextIrq;
  endtask

  // Drive one cycle of inputs, step the model and check the DUT after the edge
  task automatic applyStimulus(input logic r, input logic c, input logic re,
                               input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [NB-1:0] b);
    @(negedge clk);
    rst    = r;
    cs     = c;
    rdEn   = re;
    wrEn   = we;
    addr   = a;
    wrData = wd;
    btn    = b;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput("rd_data", rdData, mRdData);
`ifdef BUTTON_IRQ_EN
    checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
`endif
  endtask

  task automatic busRead(input logic [31:0] a, input logic [NB-1:0] b);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, a, 32'h0, b);
  endtask

  task automatic busWrite(input logic [31:0] a, input logic [31:0] wd,
                          input logic [NB-1:0] b);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, a, wd, b);
  endtask

  task automatic idle(input logic [NB-1:0] b);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, b);
  endtask

  logic [7:0] offsets[6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h00};

  initial begin
    logic [NB-1:0] b;
    logic [31:0]   a;
    $display("[TB] start");

    // Reset, reads of state/edge, idle cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, '0);
    idle('0);
    busRead(32'h0, '0);
    busRead(32'h4, '0);
    idle('0);

    // btn0 held 10 cycles while reading state every cycle, then released
    for (int k = 0; k < 10; k++) busRead(32'h0, 4'b0001);
    busRead(32'h4, 4'b0001);
    for (int k = 0; k < 8; k++) busRead(32'h0, 4'b0000);
    busRead(32'h4, 4'b0000);

    // 3-cycle glitch on btn2 must not change anything
    for (int k = 0; k < 3; k++) busRead(32'h0, 4'b0100);
    for (int k = 0; k < 6; k++) busRead((k % 2) ? 32'h4 : 32'h0, 4'b0000);

    // W1C bit 0, then clear bit 1 on the very edge its debounced rise happens
    busWrite(32'h8, 32'h1, 4'b0000);
    busRead(32'h4, 4'b0000);
    for (int k = 0; k < 5; k++) idle(4'b0010);
    busWrite(32'h8, 32'h2, 4'b0010);
    busRead(32'h4, 4'b0010);
    busRead(32'h0, 4'b0010);

`ifdef BUTTON_IRQ_EN
    busWrite(32'h8, 32'hF, 4'b0000);
    busWrite(32'hC, 32'h4, 4'b0000);
    for (int k = 0; k < 8; k++) idle(4'b0001);
    for (int k = 0; k < 8; k++) idle(4'b0101);
    busWrite(32'h8, 32'h4, 4'b0101);
    idle(4'b0101);
    busRead(32'hC, 4'b0101);
    idle(4'b0101);
`endif

    // Unmapped read, write to a read-only offset, reset mid-debounce
    busRead(32'h10, 4'b0000);
    busWrite(32'h0, 32'hFFFF_FFFF, 4'b0000);
    busRead(32'h0, 4'b0000);
    for (int k = 0; k < 4; k++) idle(4'b1000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'b1000);
    for (int k = 0; k < 8; k++) busRead(32'h0, 4'b1000);
    busRead(32'h4, 4'b1000);

    // Randomised traffic with occasional resets
    b = 4'b1000;
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 7) == 0) b[$urandom_range(0, NB - 1)] ^= 1'b1;
      a = {($urandom_range(0, 1) != 0) ? 24'($urandom) : 24'h0,
           offsets[$urandom_range(0, 5)]};
      if ($urandom_range(0, 9) == 0) a[7:0] = 8'($urandom);
      applyStimulus($urandom_range(0, 299) == 0,
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 1) != 0,
                    $urandom_range(0, 2) == 0,
                    a, $urandom, b);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
